// File: rtl/mmio_pkg.sv
// Shared constants and address-select type for the MMIO device bridge.
package mmio_pkg;

    localparam int unsigned DEV_W = 24;

    localparam logic [31:0] ADDR_LED_DFLT = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW_DFLT  = 32'hFFFF_F070;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_SW,
        SEL_LED,
        SEL_IRQ
    } addr_sel_e;

endpackage

// File: rtl/mmio_dev_bridge_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, one pair of flops per bit.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mmio_dev_bridge.sv
// MMIO bridge: debounced switch read-back, LED latch and optional switch-change
// interrupt (enabled by defining DEV_SW_IRQ_EN).
module mmio_dev_bridge
    import mmio_pkg::*;
#(
    parameter logic [31:0] ADDR_LED   = ADDR_LED_DFLT,
    parameter logic [31:0] ADDR_SW    = ADDR_SW_DFLT,
    parameter int unsigned DEB_CYCLES = 500_000,
    parameter int unsigned DEB_W      = 20
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic [31:0]      bus_addr,
    input  logic             bus_we,
    input  logic [31:0]      bus_wdata,
    output logic [31:0]      bus_rdata,
    output logic             bus_hit,
    input  logic [DEV_W-1:0] device_sw,
    output logic [DEV_W-1:0] device_led,
    output logic             sw_irq
);

    logic [DEV_W-1:0] sw_sync;
    logic [DEV_W-1:0] sw_prev;
    logic [DEV_W-1:0] sw_stable;
    logic [DEB_W-1:0] deb_cnt;
    addr_sel_e        sel;
    logic             unused_wdata_hi;

    assign unused_wdata_hi = ^bus_wdata[31:DEV_W];

    sync_2ff #(
        .WIDTH(DEV_W)
    ) u_sync (
        .clk(clk_i),
        .rst(rst),
        .d  (device_sw),
        .q  (sw_sync)
    );

    // Shared debounce counter: any movement of the synchronised value restarts it.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            sw_prev   <= '0;
            sw_stable <= '0;
            deb_cnt   <= '0;
        end else begin
            sw_prev <= sw_sync;
            if (sw_sync == sw_stable) begin
                deb_cnt <= '0;
            end else if (sw_sync != sw_prev) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
                sw_stable <= sw_sync;
                deb_cnt   <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    always_comb begin
        sel = SEL_NONE;
        if (bus_addr == ADDR_SW) begin
            sel = SEL_SW;
        end else if (bus_addr == ADDR_LED) begin
            sel = SEL_LED;
        end
`ifdef DEV_SW_IRQ_EN
        else if (bus_addr == ADDR_SW + 32'd4) begin
            sel = SEL_IRQ;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            device_led <= '0;
        end else if (bus_we && (sel == SEL_LED)) begin
            device_led <= bus_wdata[DEV_W-1:0];
        end
    end

`ifdef DEV_SW_IRQ_EN
    logic             sw_chg;
    logic [DEV_W-1:0] sw_stable_q;

    // Sticky change flag; a new change outranks a clearing write in the same cycle.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            sw_stable_q <= '0;
            sw_chg      <= 1'b0;
        end else begin
            sw_stable_q <= sw_stable;
            if (sw_stable != sw_stable_q) begin
                sw_chg <= 1'b1;
            end else if (bus_we && (sel == SEL_IRQ)) begin
                sw_chg <= 1'b0;
            end
        end
    end

    assign sw_irq = sw_chg;
`else
    assign sw_irq = 1'b0;
`endif

    // Zero-latency read path for the single-cycle CPU.
    always_comb begin
        bus_rdata = '0;
        bus_hit   = 1'b0;
        case (sel)
            SEL_SW: begin
                bus_rdata = {8'h0, sw_stable};
                bus_hit   = 1'b1;
            end
            SEL_LED: begin
                bus_rdata = {8'h0, device_led};
                bus_hit   = 1'b1;
            end
`ifdef DEV_SW_IRQ_EN
            SEL_IRQ: begin
                bus_rdata = {31'h0, sw_chg};
                bus_hit   = 1'b1;
            end
`endif
            default: begin
                bus_rdata = '0;
                bus_hit   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_dev_bridge.sv
// Directed bench for mmio_dev_bridge with DEB_CYCLES=8; define DEV_SW_IRQ_EN
// to also exercise the switch-change interrupt.
module tb_mmio_dev_bridge;

    localparam logic [31:0] A_LED = 32'hFFFF_F060;
    localparam logic [31:0] A_SW  = 32'hFFFF_F070;
    localparam logic [31:0] A_IRQ = 32'hFFFF_F074;
    localparam int unsigned NVEC  = 10;

    logic        clk_i = 1'b0;
    logic        rst;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_hit;
    logic [23:0] device_sw;
    logic [23:0] device_led;
    logic        sw_irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_hit;
        logic [23:0] exp_led;
    } vec_t;

    vec_t vecs [NVEC];

    mmio_dev_bridge #(
        .ADDR_LED  (A_LED),
        .ADDR_SW   (A_SW),
        .DEB_CYCLES(8),
        .DEB_W     (20)
    ) dut (
        .clk_i     (clk_i),
        .rst       (rst),
        .bus_addr  (bus_addr),
        .bus_we    (bus_we),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_hit   (bus_hit),
        .device_sw (device_sw),
        .device_led(device_led),
        .sw_irq    (sw_irq)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // addr, we, wdata, rdata before edge, hit, led after edge
        vecs[0] = '{A_LED,        1'b0, 32'h0,         32'h0,         1'b1, 24'h0};
        vecs[1] = '{A_LED,        1'b1, 32'hFFAB_CDEF, 32'h0,         1'b1, 24'hABCDEF};
        vecs[2] = '{A_LED,        1'b0, 32'h0,         32'h00AB_CDEF, 1'b1, 24'hABCDEF};
        vecs[3] = '{A_SW,         1'b1, 32'h1234_5678, 32'h0,         1'b1, 24'hABCDEF};
        vecs[4] = '{32'h0,        1'b1, 32'h0000_1111, 32'h0,         1'b0, 24'hABCDEF};
`ifdef DEV_SW_IRQ_EN
        vecs[5] = '{A_IRQ,        1'b0, 32'h0,         32'h0,         1'b1, 24'hABCDEF};
`else
        vecs[5] = '{A_IRQ,        1'b0, 32'h0,         32'h0,         1'b0, 24'hABCDEF};
`endif
        vecs[6] = '{A_LED,        1'b1, 32'h0000_0055, 32'h00AB_CDEF, 1'b1, 24'h000055};
        vecs[7] = '{32'hFFFF_F064, 1'b1, 32'h0000_00FF, 32'h0,        1'b0, 24'h000055};
        vecs[8] = '{A_LED,        1'b0, 32'h0,         32'h0000_0055, 1'b1, 24'h000055};
        vecs[9] = '{32'h0000_F060, 1'b0, 32'h0,        32'h0,         1'b0, 24'h000055};

        rst       = 1'b1;
        bus_addr  = A_SW;
        bus_we    = 1'b0;
        bus_wdata = 32'h0;
        device_sw = 24'h0;
        repeat (2) @(posedge clk_i);
        #1;
        check("reset_led", 32'(device_led), 32'h0);
        check("reset_sw_rdata", bus_rdata, 32'h0);
        check("reset_irq", 32'(sw_irq), 32'h0);
        rst = 1'b0;

        // Register access table
        for (int i = 0; i < int'(NVEC); i++) begin
            bus_addr  = vecs[i].addr;
            bus_we    = vecs[i].we;
            bus_wdata = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_rdata", i), bus_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_hit", i), 32'(bus_hit), 32'(vecs[i].exp_hit));
            tick();
            bus_we = 1'b0;
            check($sformatf("vec%0d_led", i), 32'(device_led), 32'(vecs[i].exp_led));
        end

        // Clean step: visible 11 edges after the input changes
        bus_addr  = A_SW;
        device_sw = 24'h000F0F;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 10) check("step_edge10", bus_rdata, 32'h0);
            if (e == 11) begin
                check("step_edge11", bus_rdata, 32'h0000_0F0F);
                check("step_irq_edge11", 32'(sw_irq), 32'h0);
            end
        end
        tick();
`ifdef DEV_SW_IRQ_EN
        check("irq_edge12", 32'(sw_irq), 32'h1);
        bus_addr = A_IRQ;
        #1;
        check("irq_flag_read", bus_rdata, 32'h1);
        check("irq_flag_hit", 32'(bus_hit), 32'h1);
        bus_we    = 1'b1;
        bus_wdata = 32'h0;
        tick();
        bus_we = 1'b0;
        check("irq_cleared", 32'(sw_irq), 32'h0);
        check("irq_flag_cleared_read", bus_rdata, 32'h0);
        bus_addr = A_SW;
`else
        check("irq_tied_low", 32'(sw_irq), 32'h0);
`endif

        // Short glitch on bit0 must never reach the stable value
        device_sw = 24'h000F0E;
        repeat (5) tick();
        device_sw = 24'h000F0F;
        for (int e = 1; e <= 14; e++) begin
            tick();
            check($sformatf("glitch_edge%0d", e), bus_rdata, 32'h0000_0F0F);
        end

        // A second movement at cycle 6 restarts qualification
        device_sw = 24'h000FFF;
        repeat (5) tick();
        device_sw = 24'h000FF0;
        for (int e = 6; e <= 16; e++) begin
            tick();
            if (e < 16) check($sformatf("restart_edge%0d", e), bus_rdata, 32'h0000_0F0F);
            else        check("restart_accept", bus_rdata, 32'h0000_0FF0);
        end

        // Reset mid-debounce discards the pending change
        device_sw = 24'h000F00;
        repeat (4) tick();
        rst = 1'b1;
        #2;
        check("midrst_led", 32'(device_led), 32'h0);
        check("midrst_sw_rdata", bus_rdata, 32'h0);
        check("midrst_irq", 32'(sw_irq), 32'h0);
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            tick();
            if (e == 10) check("requal_edge10", bus_rdata, 32'h0);
            if (e == 11) check("requal_edge11", bus_rdata, 32'h0000_0F00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
